// File: rtl/gtfraw_vnc_lat_drain_ctrl.sv
// gtfraw_vnc_lat_drain_ctrl: drains latency-monitor capture FIFO and accumulates delta statistics
// Ports:
//   axi_aclk, axi_areset          clock, async active-high reset
//   start, abort                  one-cycle control pulses from the CSR block
//   target_cnt, adj_factor        sample count and path-delay adjust, latched on start
//   lm_go, lm_clear, lm_pop       capture enable, clear pulse and pop pulse to the monitor
//   lm_datav                      monitor FIFO fill level
//   lm_snd_time, lm_rcv_time      head-of-FIFO timestamps, valid with lm_time_rdy
//   delta_accu/idx/max/min        running statistics
//   busy, done, err_timeout, aborted  status flags
// Macro LAT_DRAIN_ADJ_EN: subtract adj_factor from each delta, clamped at zero.
module gtfraw_vnc_lat_drain_ctrl #(
    parameter int TIMER_WIDTH    = 16,
    parameter int RAM_ADDR_WIDTH = 12,
    parameter int WAIT_TIMEOUT   = 1024
) (
    input  logic                      axi_aclk,
    input  logic                      axi_areset,
    input  logic                      start,
    input  logic                      abort,
    input  logic [31:0]               target_cnt,
    input  logic [TIMER_WIDTH-1:0]    adj_factor,
    output logic                      lm_go,
    output logic                      lm_clear,
    output logic                      lm_pop,
    input  logic [RAM_ADDR_WIDTH:0]   lm_datav,
    input  logic [TIMER_WIDTH-1:0]    lm_snd_time,
    input  logic [TIMER_WIDTH-1:0]    lm_rcv_time,
    input  logic                      lm_time_rdy,
    output logic [31:0]               delta_accu,
    output logic [31:0]               delta_idx,
    output logic [TIMER_WIDTH-1:0]    delta_max,
    output logic [TIMER_WIDTH-1:0]    delta_min,
    output logic                      busy,
    output logic                      done,
    output logic                      err_timeout,
    output logic                      aborted
);
    typedef enum logic [2:0] {IDLE, CLEAR, RUN, POP, WAIT, CALC, DONE} state_t;
    localparam int CW = $clog2(WAIT_TIMEOUT + 1);
    state_t state, next;
    logic [CW-1:0] wait_cnt;
    logic [31:0] target_q;
    logic [TIMER_WIDTH-1:0] snd_q, rcv_q, raw, delta;
    logic [32:0] sum;
    logic idle_st, start_acc, timeout_hit;
    assign idle_st     = state == IDLE || state == DONE;
    assign start_acc   = idle_st && start;
    assign timeout_hit = wait_cnt == CW'(WAIT_TIMEOUT - 1);
    // modular subtraction handles timer wrap between send and receive
    assign raw = rcv_q - snd_q;
`ifdef LAT_DRAIN_ADJ_EN
    logic [TIMER_WIDTH-1:0] adj_q;
    assign delta = raw >= adj_q ? raw - adj_q : '0;
`else
    logic unused_adj;
    assign unused_adj = ^adj_factor;
    assign delta = raw;
`endif
    assign sum = {1'b0, delta_accu} + 33'(delta);
    // abort has priority over every busy-state transition
    always_comb begin
        next = state;
        case (state)
            IDLE, DONE: next = start ? CLEAR : state;
            CLEAR:      next = abort ? DONE : RUN;
            RUN:        next = abort || delta_idx == target_q ? DONE : lm_datav != '0 ? POP : RUN;
            POP:        next = abort ? DONE : WAIT;
            WAIT:       next = abort ? DONE : lm_time_rdy ? CALC : timeout_hit ? DONE : WAIT;
            CALC:       next = abort ? DONE : RUN;
            default:    next = IDLE;
        endcase
    end
    // outputs are registered from the next state so they align with the state they describe
    always_ff @(posedge axi_aclk or posedge axi_areset) begin
        if (axi_areset) begin
            state       <= IDLE;
            lm_go       <= 1'b0;
            lm_clear    <= 1'b0;
            lm_pop      <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            err_timeout <= 1'b0;
            aborted     <= 1'b0;
            delta_accu  <= '0;
            delta_idx   <= '0;
            delta_max   <= '0;
            delta_min   <= '1;
            wait_cnt    <= '0;
            target_q    <= '0;
            snd_q       <= '0;
            rcv_q       <= '0;
`ifdef LAT_DRAIN_ADJ_EN
            adj_q       <= '0;
`endif
        end else begin
            state    <= next;
            lm_go    <= next inside {RUN, POP, WAIT, CALC};
            lm_clear <= next == CLEAR;
            lm_pop   <= next == POP;
            busy     <= next != IDLE && next != DONE;
            done     <= next == DONE;
            wait_cnt <= state == WAIT ? wait_cnt + 1'b1 : '0;
            if (start_acc) begin
                target_q    <= target_cnt;
`ifdef LAT_DRAIN_ADJ_EN
                adj_q       <= adj_factor;
`endif
                err_timeout <= 1'b0;
                aborted     <= 1'b0;
                delta_accu  <= '0;
                delta_idx   <= '0;
                delta_max   <= '0;
                delta_min   <= '1;
            end
            if (!idle_st && abort)
                aborted <= 1'b1;
            if (state == WAIT && !abort && !lm_time_rdy && timeout_hit)
                err_timeout <= 1'b1;
            if (state == WAIT && lm_time_rdy) begin
                snd_q <= lm_snd_time;
                rcv_q <= lm_rcv_time;
            end
            // a sample already in CALC completes even if abort arrives
            if (state == CALC) begin
                delta_accu <= sum[32] ? '1 : sum[31:0];
                delta_idx  <= delta_idx + 1;
                delta_max  <= delta > delta_max ? delta : delta_max;
                delta_min  <= delta < delta_min ? delta : delta_min;
            end
        end
    end
endmodule
